// File: rtl/bus_requester.sv
// bus_requester: queues core commands and issues them one at a time on a shared bus.
//
// Commands accepted on cmd_valid/cmd_ready go into a FIFO of FIFO_DEPTH entries. The
// FSM (IDLE -> REQ -> WAIT_ACK) raises req and holds it until the arbiter grants.
// In the grant cycle it drives the address phase combinationally and pops the head.
// It then waits for an ack tagged with CORE_ID and returns a one-cycle resp_valid
// pulse. Invalidates need no ack and complete on the cycle after the grant.
//
// Optional feature macro: BUS_REQUESTER_TIMEOUT_EN. When it is defined, the ack wait
// is bounded to TIMEOUT cycles and a timeout completes with resp_err=1. When it is
// undefined, the ack wait is unbounded and resp_err is tied low.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/ready/op/addr/wdata command push interface from the core
//   req, gnt                      arbiter request / combinational grant
//   bus_valid/op/id/addr/wdata    address phase (all zero outside the grant cycle)
//   bus_ack/ack_id/rdata          response phase from the responder
//   resp_valid/rdata/err          completion pulse back to the core
module bus_requester #(
  parameter int unsigned CORE_ID    = 0,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        req,
  input  logic        gnt,
  output logic        bus_valid,
  output logic [1:0]  bus_op,
  output logic [1:0]  bus_id,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [1:0]  bus_ack_id,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);
  localparam logic [1:0] Id = 2'(CORE_ID);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpInval = 2'b10;

  // Elaboration-time parameter range checks.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("bus_requester: FIFO_DEPTH must be a power of two in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gen_bad_timeout
    $error("bus_requester: TIMEOUT must be in 1..255");
  end
  if (CORE_ID > 3) begin : gen_bad_id
    $error("bus_requester: CORE_ID must fit in 2 bits");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWaitAck} state_e;

  state_e          state_q, state_d;
  logic [65:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, fifo_empty;
  logic [1:0]      head_op, eff_op;
  logic [31:0]     head_addr, head_wdata;
  logic            is_write_q, is_write_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            ack_match;

  // ---------------------------------------------------------------- command FIFO
  // Ready is based on the registered count, so a pop in a full cycle does not admit
  // a push in that same cycle.
  assign cmd_ready  = (count_q != Full);
  assign push       = cmd_valid & cmd_ready;
  assign fifo_empty = (count_q == '0);

  assign head_op    = mem[rd_ptr_q][65:64];
  assign head_addr  = mem[rd_ptr_q][63:32];
  assign head_wdata = mem[rd_ptr_q][31:0];
  // Reserved opcode behaves as a read.
  assign eff_op     = (head_op == 2'b11) ? OpRead : head_op;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_wdata};
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ack_match = bus_ack && (bus_ack_id == Id);

`ifdef BUS_REQUESTER_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       resp_err_q, resp_err_d;
  logic       tmo_hit;

  // Zero outside WAIT_ACK, so it is already clear on entry.
  assign tmo_cnt_d = (state_q == StWaitAck) ? tmo_cnt_q + 8'd1 : 8'd0;
  // True in the last allowed wait cycle; an ack in that cycle still takes priority.
  assign tmo_hit   = (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q  <= 8'd0;
      resp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d      = state_q;
    req          = 1'b0;
    bus_valid    = 1'b0;
    bus_op       = 2'b00;
    bus_id       = 2'b00;
    bus_addr     = 32'd0;
    bus_wdata    = 32'd0;
    pop          = 1'b0;
    is_write_d   = is_write_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
`ifdef BUS_REQUESTER_TIMEOUT_EN
    resp_err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StReq;
      end
      StReq: begin
        req = 1'b1;
        if (gnt) begin
          bus_valid = 1'b1;
          bus_op    = eff_op;
          bus_id    = Id;
          bus_addr  = head_addr;
          bus_wdata = (eff_op == OpWrite) ? head_wdata : 32'd0;
          pop       = 1'b1;
          if (eff_op == OpInval) begin
            // No response phase: complete on the next cycle with zero data.
            resp_valid_d = 1'b1;
            state_d      = StIdle;
          end else begin
            is_write_d = (eff_op == OpWrite);
            state_d    = StWaitAck;
          end
        end
      end
      StWaitAck: begin
        if (ack_match) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = is_write_q ? 32'd0 : bus_rdata;
          state_d      = fifo_empty ? StIdle : StReq;
        end
`ifdef BUS_REQUESTER_TIMEOUT_EN
        else if (tmo_hit) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = fifo_empty ? StIdle : StReq;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      is_write_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_bus_requester.sv
// Testbench for bus_requester: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model (command queue + outstanding slot).
module tb_bus_requester;

  localparam int unsigned CORE_ID = 1;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [1:0]  MyId    = 2'(CORE_ID);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        req;
  logic        gnt = 1'b0;
  logic        bus_valid;
  logic [1:0]  bus_op, bus_id;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [1:0]  bus_ack_id = 2'b00;
  logic [31:0] bus_rdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  bus_requester #(
    .CORE_ID   (CORE_ID),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .req       (req),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .bus_op    (bus_op),
    .bus_id    (bus_id),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_ack_id(bus_ack_id),
    .bus_rdata (bus_rdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Reference model state.
  cmd_t        q[$];
  bit          outstanding = 1'b0;
  bit          out_write   = 1'b0;
  int          wait_n      = 0;
  bit          exp_rv      = 1'b0;
  bit          exp_err     = 1'b0;
  logic [31:0] exp_rd      = 32'd0;

  // Values sampled in the most recent cycle.
  logic s_ready, s_bv, s_req;
  int   bv_seen = 0;
  int   resp_seen = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, then advance the model
  // across the rising edge.
  task automatic cycle(input logic cv, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic g, input logic ack,
                       input logic [1:0] aid, input logic [31:0] rd);
    cmd_t c;
    bit   nrv, nerr;
    logic [31:0] nrd;
    @(negedge clk);
    cmd_valid = cv; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    gnt = g; bus_ack = ack; bus_ack_id = aid; bus_rdata = rd;
    #1;
    chk("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
      chk("resp_err", 64'(resp_err), 64'(exp_err));
    end
    chk("bus_valid_vs_grant", 64'(bus_valid), 64'(req & gnt));
    if (q.size() == 0 || outstanding) chk("req_low", 64'(req), 64'd0);
    if (bus_valid === 1'b1) begin
      if (q.size() != 0) begin
        c = q[0];
        chk("bus_op", 64'(bus_op), 64'((c.op == 2'b11) ? 2'b00 : c.op));
        chk("bus_id", 64'(bus_id), 64'(MyId));
        chk("bus_addr", 64'(bus_addr), 64'(c.addr));
        chk("bus_wdata", 64'(bus_wdata), 64'((c.op == 2'b01) ? c.wdata : 32'd0));
      end
    end else begin
      chk("bus_hdr_idle", 64'({bus_op, bus_id}), 64'd0);
      chk("bus_data_idle", {bus_addr, bus_wdata}, 64'd0);
    end
    s_ready = cmd_ready; s_bv = bus_valid; s_req = req;
    if (bus_valid === 1'b1) bv_seen++;
    if (resp_valid === 1'b1) resp_seen++;
    @(posedge clk);
    nrv = 1'b0; nerr = 1'b0; nrd = 32'd0;
    if (s_bv === 1'b1 && q.size() != 0) begin
      c = q.pop_front();
      if (c.op == 2'b10) begin
        nrv = 1'b1;
      end else begin
        outstanding = 1'b1;
        out_write   = (c.op == 2'b01);
        wait_n      = 0;
      end
    end else if (outstanding) begin
      if (ack && aid == MyId) begin
        nrv = 1'b1;
        nrd = out_write ? 32'd0 : rd;
        outstanding = 1'b0;
      end else begin
`ifdef BUS_REQUESTER_TIMEOUT_EN
        if (wait_n + 1 == TIMEOUT) begin
          nrv = 1'b1;
          nerr = 1'b1;
          outstanding = 1'b0;
        end else wait_n++;
`else
        wait_n++;
`endif
      end
    end
    if (cv && s_ready === 1'b1) q.push_back('{op: op, addr: addr, wdata: wdata});
    exp_rv = nrv; exp_err = nerr; exp_rd = nrd;
  endtask

  task automatic pick_ack(output logic a, output logic [1:0] id, output logic [31:0] rd);
    rd = $urandom;
    if (outstanding && $urandom_range(0, 3) == 0) begin
      a = 1'b1; id = MyId;
    end else if ($urandom_range(0, 5) == 0) begin
      a = 1'b1; id = MyId ^ 2'($urandom_range(1, 3));
    end else begin
      a = 1'b0; id = 2'b00;
    end
  endtask

  task automatic drain(input int bound);
    logic a;
    logic [1:0] id;
    logic [31:0] rd;
    int k = 0;
    while ((q.size() != 0 || outstanding || exp_rv) && k < bound) begin
      pick_ack(a, id, rd);
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'($urandom_range(0, 1)), a, id, rd);
      k++;
    end
    chk("drain_done", 64'(k < bound), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; gnt = 1'b0; bus_ack = 1'b0;
    #1;
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete(); outstanding = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_rd = 32'd0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int   k;
    logic accepted;
    logic a;
    logic [1:0] id;
    logic [31:0] rd;

    do_reset();

    // Read, granted on first REQ cycle, acked on the third wait cycle.
    bv_seen = 0; resp_seen = 0;
    cycle(1'b1, 2'b00, 32'h100, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
    k = 0;
    while (s_bv !== 1'b1 && k < 6) begin
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
      k++;
    end
    chk("t035_granted", 64'(s_bv), 64'd1);
    repeat (2) cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, MyId, 32'hDEADBEEF);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
    chk("t035_one_bus_valid", 64'(bv_seen), 64'd1);
    chk("t035_one_resp", 64'(resp_seen), 64'd1);

    // Grant withheld for 5 REQ cycles, then given.
    cycle(1'b1, 2'b00, 32'h200, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
    k = 0;
    while (s_req !== 1'b1 && k < 4) begin
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
      k++;
    end
    chk("t036_req_rise", 64'(s_req), 64'd1);
    repeat (4) begin
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
      chk("t036_req_hold", 64'(s_req), 64'd1);
      chk("t036_no_bus_valid", 64'(s_bv), 64'd0);
    end
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
    chk("t036_bus_valid_6th", 64'(s_bv), 64'd1);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, MyId, 32'h1234_5678);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);

    // Three back-to-back pushes into a 2-deep queue; then a mismatched ack.
    resp_seen = 0;
    cycle(1'b1, 2'b01, 32'h0A00, 32'hAAAA_0001, 1'b0, 1'b0, 2'b00, 32'd0);
    cycle(1'b1, 2'b00, 32'h0B00, 32'hBBBB_0002, 1'b0, 1'b0, 2'b00, 32'd0);
    cycle(1'b1, 2'b11, 32'h0C00, 32'hCCCC_0003, 1'b0, 1'b0, 2'b00, 32'd0);
    chk("t037_full_not_ready", 64'(s_ready), 64'd0);
    accepted = 1'b0; k = 0;
    while (!accepted && k < 10) begin
      cycle(1'b1, 2'b11, 32'h0C00, 32'hCCCC_0003, 1'b1, 1'b0, 2'b00, 32'd0);
      accepted = s_ready; k++;
    end
    chk("t037_third_accepted", 64'(accepted), 64'd1);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, MyId ^ 2'b10, 32'hBAD0_BAD0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
    chk("t038_no_resp_on_foreign_ack", 64'(resp_seen), 64'd0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, MyId, 32'h5555_AAAA);
    drain(200);
    chk("t037_three_responses", 64'(resp_seen), 64'd3);

    // No ack at all for a read.
    cycle(1'b1, 2'b00, 32'h300, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
    k = 0;
    while (s_bv !== 1'b1 && k < 6) begin
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
      k++;
    end
    resp_seen = 0;
    repeat (TIMEOUT + 5) cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
`ifdef BUS_REQUESTER_TIMEOUT_EN
    chk("t039_timeout_resp", 64'(resp_seen), 64'd1);
`else
    chk("t039_still_waiting", 64'(resp_seen), 64'd0);
`endif
    drain(200);

    // Randomized traffic.
    repeat (1500) begin
      pick_ack(a, id, rd);
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom_range(0, 2) == 0), a, id, rd);
    end
    drain(400);

    // Reset while waiting for an ack with one command still queued.
    cycle(1'b1, 2'b00, 32'h400, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
    cycle(1'b1, 2'b01, 32'h404, 32'h0404_0404, 1'b0, 1'b0, 2'b00, 32'd0);
    k = 0;
    do begin
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0);
      k++;
    end while (s_bv !== 1'b1 && k < 6);
    chk("t040_granted", 64'(s_bv), 64'd1);
    do_reset();
    resp_seen = 0;
    repeat (20) cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, MyId, 32'hFFFF_0000);
    chk("t040_no_resp_after_reset", 64'(resp_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 Parameter CORE_ID, default 0, 2-bit requester index placed on bus_id and matched against bus_ack_id.
REQ-002 Parameter FIFO_DEPTH, default 2, command queue depth (power of two, 2..8).
REQ-003 Parameter TIMEOUT, default 15, ack-wait limit in cycles (1..255).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  core offers a command.
REQ-007 cmd_ready  out  1  queue can accept; high iff queue not full.
REQ-008 cmd_op  in  2  00 read, 01 write, 10 invalidate, 11 reserved (treated as read).
REQ-009 cmd_addr  in  32  command address.
REQ-010 cmd_wdata  in  32  write data (ignored unless write).
REQ-011 req  out  1  bus request to arbiter.
REQ-012 gnt  in  1  combinational grant from arbiter, valid only in the cycle sampled.
REQ-013 bus_valid  out  1  address phase strobe.
REQ-014 bus_op / bus_id / bus_addr / bus_wdata  out  2/2/32/32  address-phase fields.
REQ-015 bus_ack / bus_ack_id / bus_rdata  in  1/2/32  response phase from responder.
REQ-016 resp_valid  out  1  one-cycle completion pulse to core.
REQ-017 resp_rdata  out  32  read data, valid with resp_valid.
REQ-018 resp_err  out  1  timeout flag, valid with resp_valid.

Function
REQ-019 Handshake cmd_valid&cmd_ready pushes {op,addr,wdata} into FIFO; FIFO pop occurs only at address-phase completion.
REQ-020 States IDLE, REQ, WAIT_ACK; one transaction outstanding at a time.
REQ-021 IDLE -> REQ next cycle when FIFO non-empty; req asserted in REQ only.
REQ-022 Arbiter grant rotates per cycle; req SHALL stay high in REQ until a cycle with gnt=1, for any number of cycles.
REQ-023 In REQ with gnt=1: bus_valid=1 same cycle (combinational from state&gnt), fields from FIFO head, head popped, next state WAIT_ACK (invalidate: next state IDLE, resp_valid pulsed next cycle, rdata 0).
REQ-024 bus_valid and bus fields SHALL be 0 in all other cycles.
REQ-025 WAIT_ACK: req=0; on bus_ack=1 with bus_ack_id==CORE_ID: resp_valid=1 next cycle, resp_rdata=bus_rdata (0 for write), resp_err=0, next state IDLE (or REQ if FIFO non-empty after pop).
REQ-026 bus_ack with non-matching id ignored.
REQ-027 Push and pop in same cycle when full: push accepted only if cmd_ready was high that cycle (ready computed before pop).
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-029 Commands complete to the core in push order.

Reset
REQ-030 rst SHALL force state IDLE, FIFO empty, req=0, bus_valid=0, resp_valid=0, resp_err=0, resp_rdata=0, timeout counter 0, cmd_ready=1 after release.
REQ-031 rst mid-transaction discards queued and outstanding commands; no resp_valid for them.

Configuration
REQ-032 Macro BUS_REQUESTER_TIMEOUT_EN: when defined, 8-bit counter cleared on entering WAIT_ACK, increments each WAIT_ACK cycle; reaching TIMEOUT without matching ack -> resp_valid=1, resp_err=1, resp_rdata=0, leave WAIT_ACK.
REQ-033 When undefined: no counter, WAIT_ACK waits indefinitely, resp_err tied 0.
REQ-034 Ack arriving in same cycle counter reaches TIMEOUT SHALL win (resp_err=0).

Verification
REQ-035 Read addr 0x100, gnt high first REQ cycle, ack id=CORE_ID rdata 0xDEADBEEF 3 cycles later -> one bus_valid cycle, resp_valid with 0xDEADBEEF, resp_err=0.
REQ-036 gnt low 5 cycles then high -> req held 6 cycles, bus_valid exactly in 6th.
REQ-037 Push 3 commands back-to-back, FIFO_DEPTH=2 -> cmd_ready low after 2nd until first pop; three responses in order.
REQ-038 Ack with bus_ack_id != CORE_ID -> no resp_valid; later matching ack completes.
REQ-039 TIMEOUT_EN, TIMEOUT=15, no ack -> resp_valid with resp_err=1 after 15 WAIT_ACK cycles; without macro stays in WAIT_ACK.
REQ-040 rst asserted in WAIT_ACK with 1 queued -> req=0, cmd_ready=1, no responses after release.
